// File: rtl/fifo_empty_if.sv
// Read-side handshake bundle of the async FIFO: request, synchronised write pointer, and read-domain status.
interface fifo_empty_if #(
    parameter int unsigned ADDR_SIZE = 4
);
    logic                 rd_en;
    logic [ADDR_SIZE:0]   wr_ptr_addr_sync;
    logic                 empty;
    logic [ADDR_SIZE:0]   rd_addr_grey;
    logic [ADDR_SIZE-1:0] rd_addr_bin;
    logic                 underflow;
    logic [ADDR_SIZE:0]   rd_level;
    logic                 almost_empty;

    modport master (
        output rd_en,
        output wr_ptr_addr_sync,
        input  empty,
        input  rd_addr_grey,
        input  rd_addr_bin,
        input  underflow,
        input  rd_level,
        input  almost_empty
    );

    modport slave (
        input  rd_en,
        input  wr_ptr_addr_sync,
        output empty,
        output rd_addr_grey,
        output rd_addr_bin,
        output underflow,
        output rd_level,
        output almost_empty
    );
endinterface

// File: rtl/fifo_empty.sv
// Async FIFO read-side pointer, registered empty flag and sticky underflow.
// Optional fill level / almost_empty enabled by defining FIFO_RD_LEVEL_EN.
module fifo_empty #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input logic         rd_clk,
    input logic         rd_rst,
    fifo_empty_if.slave rd_if
);
    localparam int unsigned PW = ADDR_SIZE + 1;

    if (AE_THRESH > (1 << ADDR_SIZE)) begin : g_thresh_check
        $error("fifo_empty: AE_THRESH exceeds FIFO depth");
    end

    logic [PW-1:0] rd_bin_r;
    logic [PW-1:0] rd_grey_r;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_grey_next;
    logic          rd_accept;
    logic          empty_r;
    logic          underflow_r;

    always_comb begin
        rd_accept    = rd_if.rd_en & ~empty_r;
        rd_bin_next  = rd_bin_r + {{ADDR_SIZE{1'b0}}, rd_accept};
        rd_grey_next = (rd_bin_next >> 1) ^ rd_bin_next;
    end

    // Empty compares the next pointer with the current sync value, so the last read flags empty on its own edge.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin_r    <= '0;
            rd_grey_r   <= '0;
            empty_r     <= 1'b1;
            underflow_r <= 1'b0;
        end else begin
            rd_bin_r    <= rd_bin_next;
            rd_grey_r   <= rd_grey_next;
            empty_r     <= (rd_grey_next == rd_if.wr_ptr_addr_sync);
            underflow_r <= underflow_r | (rd_if.rd_en & empty_r);
        end
    end

    assign rd_if.empty        = empty_r;
    assign rd_if.rd_addr_grey = rd_grey_r;
    assign rd_if.rd_addr_bin  = rd_bin_r[ADDR_SIZE-1:0];
    assign rd_if.underflow    = underflow_r;

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [PW-1:0] grey2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rd_level_r;
    logic          almost_empty_r;

    // Level uses the registered write pointer, so it trails empty by one cycle and can only under-report.
    always_comb begin
        level_next = wr_bin_s - rd_bin_next;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wr_bin_s       <= '0;
            rd_level_r     <= '0;
            almost_empty_r <= 1'b1;
        end else begin
            wr_bin_s       <= grey2bin(rd_if.wr_ptr_addr_sync);
            rd_level_r     <= level_next;
            almost_empty_r <= (level_next <= PW'(AE_THRESH));
        end
    end

    assign rd_if.rd_level     = rd_level_r;
    assign rd_if.almost_empty = almost_empty_r;
`else
    assign rd_if.rd_level     = '0;
    assign rd_if.almost_empty = empty_r;
`endif
endmodule
